xadc_axi_sampler: RTL and testbench
===================================

# xadc_axi_sampler

AXI4-Lite read master that periodically sweeps a fixed set of XADC Wizard status registers and emits each conversion result as a tagged sample on an AXI4-Stream output. It sits between the AXI XADC Wizard slave and the oscilloscope capture/trigger path, turning register polling into a continuous sample stream. It reports per-sweep completion and a sticky bus error, using the same done/error semantics as the team's existing AXI master IP.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width (only 32 is supported)
- C_XADC_BASE_ADDR, 32'h43C0_0000, XADC Wizard base address
- C_STATUS_OFFSET, 32'h0000_020C, offset of the first channel status register
- C_NUM_CH, 4, channels per sweep (1..16); channel n is read at BASE+OFFSET+4*n
- C_SAMPLE_DIV, 1000, ACLK cycles between sweep starts (>=2)

Ports:
- ACLK  in  1  clock; all logic is on the rising edge
- ARESETN  in  1  asynchronous active-low reset
- ENABLE  in  1  level; while high, a sweep is started every C_SAMPLE_DIV cycles
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID / M_AXI_ARREADY  out / in  1  read address handshake
- M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID / M_AXI_RREADY  in / out  1  read data handshake
- AW/W/B channels: AWVALID, WVALID, BREADY tied 0; addresses/data tied 0
- M_AXIS_TDATA  out  16  {channel[3:0], sample[11:0]}
- M_AXIS_TVALID / M_AXIS_TREADY  out / in  1  stream handshake
- M_AXIS_TLAST  out  1  high on the last channel of a sweep
- TXN_DONE  out  1  one-cycle pulse when a sweep's last sample is accepted
- ERROR  out  1  sticky; set on RRESP != OKAY (or timeout, see Configuration)

## Operation
- FSM states: IDLE, ADDR, DATA, PUSH.
- Tick counter: free-running 0..C_SAMPLE_DIV-1 while ENABLE is high; held at 0 while ENABLE is low. Terminal count sets a pending flag. A tick arriving while the flag is already set is dropped, so at most one sweep is queued.
- IDLE: if the pending flag is set, clear it, set ch=0, and go to ADDR.
- ADDR: ARVALID=1, ARADDR=BASE+OFFSET+4*ch; address and valid are held stable until ARREADY. On the handshake, go to DATA.
- DATA: RREADY=1. On RVALID, capture sample=RDATA[15:4] (XADC 12-bit left-justified). If RRESP != 2'b00, set ERROR; the sample is still pushed. Go to PUSH.
- PUSH: TVALID=1 with TDATA/TLAST held stable until TREADY. On the handshake: if ch==C_NUM_CH-1, pulse TXN_DONE and go to IDLE; otherwise ch++ and go to ADDR.
- ERROR clears only on reset or on the rising edge of ENABLE.
- ENABLE falling mid-sweep: the current sweep completes and the pending flag is cleared.

## Timing
- Reset values: ARVALID, RREADY, TVALID, TLAST, TXN_DONE, ERROR all 0; ARADDR=BASE+OFFSET; TDATA=0; FSM=IDLE; counter=0; pending=0.
- ARVALID is registered and rises the cycle after IDLE sees pending.
- With zero-wait slaves, the first sample has TVALID high 4 cycles after the tick: pending, ADDR, DATA, PUSH.
- Each channel takes at least 3 cycles, so the minimum sweep is 3*C_NUM_CH cycles. If the sweep is longer than C_SAMPLE_DIV, ticks queue as defined above.
- No combinational path from any input to any output.
- Reset asserted mid-transaction: all outputs drop asynchronously. The slave's outstanding response is not awaited.

## Configuration
- XADC_SAMPLER_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles spent in ADDR or DATA and resets on each handshake.
  - At 16'hFFFF it sets ERROR, abandons the sweep (no TXN_DONE), and returns to IDLE.
- Not defined: no watchdog; the master waits indefinitely.

## Structure
- Shared package xadc_sampler_pkg holds:
  - state enum typedef
  - RESP_OKAY constant
  - default XADC offset constants
  - sample-tag width constant (4)
- No sub-module required. If buffering is later needed, the PUSH register may be replaced by axis_skid_buffer.

## Test plan
- Reset, ENABLE=1, C_NUM_CH=4, DIV=100, slave returns RDATA=32'h0000_ABC0 -> four beats TDATA=16'h0ABC..16'h3ABC, ARADDR 0x43C0020C/210/214/218, TLAST on beat 4, one TXN_DONE.
- TREADY low for 10 cycles on beat 2 -> TDATA/TVALID stable, no new ARVALID until accepted.
- Slave returns RRESP=2'b10 on ch1 -> ERROR=1 and stays 1; sweep still finishes; ERROR clears on the next ENABLE rise.
- DIV=5, slave ARREADY delayed 20 cycles -> exactly one queued sweep follows; no double-issue, no lost TLAST.
- ARESETN pulsed low during DATA -> all outputs 0 immediately; after release, the next sweep starts at ch0.
- With XADC_SAMPLER_TIMEOUT_EN, ARREADY held 0 -> ERROR after 65535 cycles, FSM in IDLE, no TXN_DONE.

Source files
------------

// File: rtl/xadc_sampler_pkg.sv
// Shared types and constants for the XADC AXI sampler.
// The optional read-channel watchdog lives in xadc_axi_sampler (XADC_SAMPLER_TIMEOUT_EN).
package xadc_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_PUSH = 2'd3
    } state_t;

    localparam logic [1:0]  RESP_OKAY                  = 2'b00;
    localparam logic [31:0] XADC_BASE_ADDR_DEFAULT     = 32'h43C0_0000;
    localparam logic [31:0] XADC_STATUS_OFFSET_DEFAULT = 32'h0000_020C;
    localparam int          TAG_WIDTH                  = 4;
    localparam int          SAMPLE_WIDTH               = 12;

    // Byte address of one channel status register (registers are 32-bit spaced).
    function automatic logic [31:0] ch_addr(
        input logic [31:0]          base,
        input logic [31:0]          offset,
        input logic [TAG_WIDTH-1:0] ch
    );
        return base + offset + {26'd0, ch, 2'b00};
    endfunction

endpackage

// File: rtl/xadc_axi_sampler.sv
// AXI4-Lite read master that sweeps XADC status registers into a tagged AXI4-Stream feed.
// Define XADC_SAMPLER_TIMEOUT_EN to add a 16-bit watchdog on the AR/R channels.
module xadc_axi_sampler
    import xadc_sampler_pkg::*;
#(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_XADC_BASE_ADDR   = XADC_BASE_ADDR_DEFAULT,
    parameter logic [31:0] C_STATUS_OFFSET    = XADC_STATUS_OFFSET_DEFAULT,
    parameter int          C_NUM_CH           = 4,
    parameter int          C_SAMPLE_DIV       = 1000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            ENABLE,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    output logic                            M_AXI_BREADY,
    output logic [15:0]                     M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic                            M_AXIS_TLAST,
    output logic                            TXN_DONE,
    output logic                            ERROR
);

    localparam int CNT_W = (C_SAMPLE_DIV > 2) ? $clog2(C_SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0]              CNT_LAST   = CNT_W'(C_SAMPLE_DIV - 1);
    localparam logic [TAG_WIDTH-1:0]          LAST_CH    = TAG_WIDTH'(C_NUM_CH - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_FIRST =
        C_M_AXI_ADDR_WIDTH'(ch_addr(C_XADC_BASE_ADDR, C_STATUS_OFFSET, 4'd0));

    state_t                          state_r, state_nxt_s;
    logic [TAG_WIDTH-1:0]            ch_r, ch_nxt_s, ch_inc_s;
    logic [CNT_W-1:0]                tick_cnt_r;
    logic                            tick_s;
    logic                            pending_r;
    logic                            consume_s;
    logic                            enable_d_r;
    logic                            enable_rise_s;
    logic                            error_r;
    logic                            resp_err_s;
    logic                            abort_s;
    logic                            timeout_s;
    logic                            arvalid_r, arvalid_nxt_s;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_r, araddr_nxt_s;
    logic                            rready_r, rready_nxt_s;
    logic                            tvalid_r, tvalid_nxt_s;
    logic [15:0]                     tdata_r, tdata_nxt_s;
    logic                            tlast_r, tlast_nxt_s;
    logic                            txn_done_r, txn_done_nxt_s;
    logic                            rdata_unused_s;

    assign tick_s        = ENABLE && (tick_cnt_r == CNT_LAST);
    assign enable_rise_s = ENABLE && !enable_d_r;
    assign ch_inc_s      = ch_r + 4'd1;
    assign rdata_unused_s = ^{M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:16], M_AXI_RDATA[3:0]};

`ifdef XADC_SAMPLER_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;
    logic [15:0] wdog_r;
    logic        wdog_active_s;
    logic        wdog_hs_s;

    assign wdog_active_s = (state_r == ST_ADDR) || (state_r == ST_DATA);
    assign wdog_hs_s     = ((state_r == ST_ADDR) && M_AXI_ARREADY) ||
                           ((state_r == ST_DATA) && M_AXI_RVALID);
    assign timeout_s     = wdog_active_s && (wdog_r == WDOG_LIMIT);

    // Watchdog: cycles spent waiting on the current AR or R handshake
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wdog_r <= 16'h0000;
        end else if (!wdog_active_s || wdog_hs_s) begin
            wdog_r <= 16'h0000;
        end else begin
            wdog_r <= wdog_r + 16'h0001;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Sweep-period tick counter, held at zero while disabled
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tick_cnt_r <= {CNT_W{1'b0}};
        end else if (!ENABLE || tick_s) begin
            tick_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
        end
    end

    // Single-deep sweep request queue; extra ticks are dropped while it is full
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pending_r <= 1'b0;
        end else if (!ENABLE || consume_s) begin
            pending_r <= 1'b0;
        end else if (tick_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Sticky bus error, re-armed by a rising ENABLE; a new error wins over the clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            enable_d_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            enable_d_r <= ENABLE;
            if (resp_err_s || abort_s) begin
                error_r <= 1'b1;
            end else if (enable_rise_s) begin
                error_r <= 1'b0;
            end else begin
                error_r <= error_r;
            end
        end
    end

    // Next-state and next-output logic; all bus outputs are registered from these
    always_comb begin
        state_nxt_s    = state_r;
        ch_nxt_s       = ch_r;
        arvalid_nxt_s  = arvalid_r;
        araddr_nxt_s   = araddr_r;
        rready_nxt_s   = rready_r;
        tvalid_nxt_s   = tvalid_r;
        tdata_nxt_s    = tdata_r;
        tlast_nxt_s    = tlast_r;
        txn_done_nxt_s = 1'b0;
        consume_s      = 1'b0;
        resp_err_s     = 1'b0;
        abort_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_r) begin
                    consume_s     = 1'b1;
                    ch_nxt_s      = 4'd0;
                    arvalid_nxt_s = 1'b1;
                    araddr_nxt_s  = ADDR_FIRST;
                    state_nxt_s   = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                    state_nxt_s   = ST_DATA;
                end else if (timeout_s) begin
                    abort_s       = 1'b1;
                    arvalid_nxt_s = 1'b0;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_nxt_s = 1'b0;
                    tvalid_nxt_s = 1'b1;
                    // XADC results are 12-bit, left-justified in the low half-word
                    tdata_nxt_s  = {ch_r, M_AXI_RDATA[SAMPLE_WIDTH+3:4]};
                    tlast_nxt_s  = (ch_r == LAST_CH);
                    resp_err_s   = (M_AXI_RRESP != RESP_OKAY);
                    state_nxt_s  = ST_PUSH;
                end else if (timeout_s) begin
                    abort_s      = 1'b1;
                    rready_nxt_s = 1'b0;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PUSH: begin
                if (M_AXIS_TREADY) begin
                    tvalid_nxt_s = 1'b0;
                    tlast_nxt_s  = 1'b0;
                    if (ch_r == LAST_CH) begin
                        txn_done_nxt_s = 1'b1;
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        ch_nxt_s      = ch_inc_s;
                        arvalid_nxt_s = 1'b1;
                        araddr_nxt_s  = C_M_AXI_ADDR_WIDTH'(
                            ch_addr(C_XADC_BASE_ADDR, C_STATUS_OFFSET, ch_inc_s));
                        state_nxt_s   = ST_ADDR;
                    end
                end else begin
                    state_nxt_s = ST_PUSH;
                end
            end
            default: begin
                arvalid_nxt_s = 1'b0;
                rready_nxt_s  = 1'b0;
                tvalid_nxt_s  = 1'b0;
                tlast_nxt_s   = 1'b0;
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered bus outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r    <= ST_IDLE;
            ch_r       <= 4'd0;
            arvalid_r  <= 1'b0;
            araddr_r   <= ADDR_FIRST;
            rready_r   <= 1'b0;
            tvalid_r   <= 1'b0;
            tdata_r    <= 16'h0000;
            tlast_r    <= 1'b0;
            txn_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ch_r       <= ch_nxt_s;
            arvalid_r  <= arvalid_nxt_s;
            araddr_r   <= araddr_nxt_s;
            rready_r   <= rready_nxt_s;
            tvalid_r   <= tvalid_nxt_s;
            tdata_r    <= tdata_nxt_s;
            tlast_r    <= tlast_nxt_s;
            txn_done_r <= txn_done_nxt_s;
        end
    end

    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;
    assign M_AXI_AWADDR  = {C_M_AXI_ADDR_WIDTH{1'b0}};
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WDATA   = {C_M_AXI_DATA_WIDTH{1'b0}};
    assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b0}};
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b0;
    assign M_AXIS_TDATA  = tdata_r;
    assign M_AXIS_TVALID = tvalid_r;
    assign M_AXIS_TLAST  = tlast_r;
    assign TXN_DONE      = txn_done_r;
    assign ERROR         = error_r;

endmodule

// File: tb/tb_xadc_axi_sampler.sv
// Directed self-checking bench for xadc_axi_sampler with a behavioural AXI4-Lite slave.
// The watchdog step runs only when XADC_SAMPLER_TIMEOUT_EN is defined.
module tb_xadc_axi_sampler;

    localparam int DIV = 20;
    localparam logic [31:0] A0 = 32'h43C0_020C;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        ENABLE = 1'b0;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_BREADY;
    logic [15:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;
    logic        TXN_DONE;
    logic        ERROR;

    int errors = 0;
    int checks = 0;
    int ar_delay = 0;
    int err_ch = -1;
    logic [31:0] ar_log[$];

    xadc_axi_sampler #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_XADC_BASE_ADDR  (32'h43C0_0000),
        .C_STATUS_OFFSET   (32'h0000_020C),
        .C_NUM_CH          (4),
        .C_SAMPLE_DIV      (DIV)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .ENABLE       (ENABLE),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARPROT (M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY),
        .M_AXI_AWADDR (M_AXI_AWADDR),
        .M_AXI_AWPROT (M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_WDATA  (M_AXI_WDATA),
        .M_AXI_WSTRB  (M_AXI_WSTRB),
        .M_AXI_WVALID (M_AXI_WVALID),
        .M_AXI_BREADY (M_AXI_BREADY),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .TXN_DONE     (TXN_DONE),
        .ERROR        (ERROR)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for the next beat, then checks its channel tag, sample and TLAST.
    task automatic expect_beat(input int ch, input int budget);
        int n = 0;
        logic [15:0] exp_data;
        exp_data = 16'h0ABC | (16'(ch) << 12);
        @(negedge ACLK);
        while (!M_AXIS_TVALID && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        check($sformatf("beat%0d tvalid", ch), {31'd0, M_AXIS_TVALID}, 32'd1);
        check($sformatf("beat%0d tdata", ch), {16'd0, M_AXIS_TDATA}, {16'd0, exp_data});
        check($sformatf("beat%0d tlast", ch), {31'd0, M_AXIS_TLAST}, (ch == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic finish_sweep(input int from_ch, input int budget);
        for (int c = from_ch; c < 4; c++) expect_beat(c, budget);
        @(negedge ACLK);
        check("txn_done pulse", {31'd0, TXN_DONE}, 32'd1);
    endtask

    // Slave model: inputs change on the falling edge, seen by the DUT on the next rising edge
    initial begin : slave
        int ar_cnt = 0;
        bit ar_fire = 1'b0;
        bit r_fire = 1'b0;
        logic [31:0] a = 32'd0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA = 32'd0;
        M_AXI_RRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                M_AXI_ARREADY = 1'b0;
                M_AXI_RVALID = 1'b0;
                ar_fire = 1'b0;
                r_fire = 1'b0;
                ar_cnt = 0;
            end else begin
                if (r_fire) M_AXI_RVALID = 1'b0;
                if (ar_fire) begin
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA = 32'h0000_ABC0;
                    M_AXI_RRESP = (int'(a - A0) == err_ch * 4) ? 2'b10 : 2'b00;
                end
                if (M_AXI_ARVALID) begin
                    M_AXI_ARREADY = (ar_cnt >= ar_delay);
                    ar_cnt++;
                end else begin
                    M_AXI_ARREADY = 1'b0;
                    ar_cnt = 0;
                end
                ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
                if (ar_fire) begin
                    a = M_AXI_ARADDR;
                    ar_log.push_back(a);
                    ar_cnt = 0;
                end
                r_fire = M_AXI_RVALID && M_AXI_RREADY;
            end
        end
    end

    initial begin : stim
        int n;
        int base;
        M_AXIS_TREADY = 1'b1;

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
        check("rst araddr", M_AXI_ARADDR, A0);
        check("rst rready", {31'd0, M_AXI_RREADY}, 32'd0);
        check("rst tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        check("rst tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
        check("rst tdata", {16'd0, M_AXIS_TDATA}, 32'd0);
        check("rst txn_done", {31'd0, TXN_DONE}, 32'd0);
        check("rst error", {31'd0, ERROR}, 32'd0);
        check("arprot", {29'd0, M_AXI_ARPROT}, 32'd0);
        check("awvalid", {31'd0, M_AXI_AWVALID}, 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Basic sweep: tick at count DIV-1, then pending, ADDR, DATA, PUSH
        ENABLE = 1'b1;
        n = 0;
        while (!M_AXIS_TVALID && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        check("first beat latency", n, DIV + 3);
        check("beat0 tdata", {16'd0, M_AXIS_TDATA}, 32'h0000_0ABC);
        check("beat0 tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
        finish_sweep(1, 30);
        check("ar count sweep1", ar_log.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("araddr ch%0d", i), ar_log[i], A0 + 32'(4 * i));
        check("no error sweep1", {31'd0, ERROR}, 32'd0);

        // Back-pressure on the second beat
        expect_beat(0, 60);
        @(negedge ACLK);
        M_AXIS_TREADY = 1'b0;
        expect_beat(1, 30);
        base = ar_log.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            check("stall tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
            check("stall tdata", {16'd0, M_AXIS_TDATA}, 32'h0000_1ABC);
            check("stall arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
        end
        check("stall no new ar", ar_log.size(), base);
        M_AXIS_TREADY = 1'b1;
        finish_sweep(2, 30);

        // Error response on channel 1 (queued sweep starts right away)
        err_ch = 1;
        expect_beat(0, 60);
        expect_beat(1, 30);
        check("error set", {31'd0, ERROR}, 32'd1);
        finish_sweep(2, 30);
        check("error sticky", {31'd0, ERROR}, 32'd1);
        err_ch = -1;
        ENABLE = 1'b0;
        repeat (60) @(negedge ACLK);
        check("disabled error held", {31'd0, ERROR}, 32'd1);
        check("disabled idle arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
        check("disabled idle tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        ENABLE = 1'b1;
        @(negedge ACLK);
        check("error cleared on enable rise", {31'd0, ERROR}, 32'd0);

        // Slow ARREADY: sweep outlasts the period, exactly one sweep is queued
        base = ar_log.size();
        ar_delay = 30;
        finish_sweep(0, 200);
        check("slow sweep ar count", ar_log.size(), base + 4);
        ar_delay = 0;
        @(negedge ACLK);
        check("queued sweep starts", {31'd0, M_AXI_ARVALID}, 32'd1);
        check("queued sweep araddr", M_AXI_ARADDR, A0);
        finish_sweep(0, 30);
        check("queued sweep ar count", ar_log.size(), base + 8);

        // Reset while a read response is outstanding
        n = 0;
        while (!M_AXI_RREADY && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        check("reached data phase", {31'd0, M_AXI_RREADY}, 32'd1);
        ARESETN = 1'b0;
        #1;
        check("async rst rready", {31'd0, M_AXI_RREADY}, 32'd0);
        check("async rst arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
        check("async rst tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        check("async rst tdata", {16'd0, M_AXIS_TDATA}, 32'd0);
        check("async rst araddr", M_AXI_ARADDR, A0);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        base = ar_log.size();
        expect_beat(0, 60);
        check("post-reset first ar", ar_log[base], A0);
        finish_sweep(1, 30);

`ifdef XADC_SAMPLER_TIMEOUT_EN
        // Watchdog: ARREADY never arrives
        ar_delay = 1000000;
        n = 0;
        base = 0;
        while (!ERROR && n < 70000) begin
            @(negedge ACLK);
            if (TXN_DONE) base++;
            n++;
        end
        check("timeout error", {31'd0, ERROR}, 32'd1);
        check("timeout arvalid dropped", {31'd0, M_AXI_ARVALID}, 32'd0);
        check("timeout no txn_done", base, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
